// File: rtl/dualmem_req_ctrl.sv
// Request controller in front of a 2048 x 64-bit single-port memory: post-reset
// zero-fill, byte-enabled writes, and credit-limited in-order read responses.
module dualmem_req_ctrl #(
    parameter int RSP_DEPTH = 2,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [10:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        init_done,
    output logic        mem_en,
    output logic [7:0]  mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;
    localparam state_t RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

    state_t        state, state_nxt;
    logic          live;
    logic [10:0]   init_cnt;
    logic          inflight;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   fifo_mem [RSP_DEPTH];
    logic          rdy, rd_accept, push, pop;
    logic [CW:0]   credit;

    assign push      = inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (count != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign req_ready = rdy;
    assign init_done = live && (state != ST_INIT);

    // An entry leaving this cycle frees its slot for the new read; without that
    // a back-to-back read stream could not sustain one read per cycle.
    assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        rd_accept = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 8'h00;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_INIT: begin
                if (live) begin
                    mem_en   = 1'b1;
                    mem_we   = 8'hFF;
                    mem_addr = init_cnt;
                    if (init_cnt == 11'h7FF) state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_FLUSH: begin
                if (live) begin
                    rdy       = req_we || (credit < DEPTH_C);
                    mem_en    = req_valid && rdy;
                    mem_we    = (mem_en && req_we) ? req_be : 8'h00;
                    mem_addr  = req_addr;
                    mem_wdata = req_wdata;
                    rd_accept = mem_en && !req_we;
                    state_nxt = (state == ST_RUN && !req_valid && inflight) ? ST_FLUSH : ST_RUN;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // live holds everything quiet for the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RST_STATE;
            live     <= 1'b0;
            init_cnt <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            live     <= 1'b1;
            inflight <= rd_accept;
            if (state == ST_INIT && live) init_cnt <= init_cnt + 11'd1;
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end
endmodule
